// File: rtl/exe_stage_p.sv
// Y86-64 execute stage: computes valE/Cnd, owns the ZF/SF/OF condition codes,
// and registers the result as the E->M pipeline register with valid/ready flow control.
module exe_stage_p #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned STACK_STEP = WIDTH / 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_icode,
    input  logic [3:0]       in_ifun,
    input  logic [WIDTH-1:0] in_val_a,
    input  logic [WIDTH-1:0] in_val_b,
    input  logic [WIDTH-1:0] in_val_c,
    input  logic [3:0]       in_dst_e,
    input  logic             set_cc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_icode,
    output logic [3:0]       out_ifun,
    output logic [WIDTH-1:0] out_val_e,
    output logic [WIDTH-1:0] out_val_a,
    output logic [3:0]       out_dst_e,
    output logic             out_cnd,
    output logic             out_err,
    output logic [2:0]       cc_out
);

    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOV   = 4'h2;
    localparam logic [3:0] I_IRMOV  = 4'h3;
    localparam logic [3:0] I_RMMOV  = 4'h4;
    localparam logic [3:0] I_MRMOV  = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSH   = 4'hA;
    localparam logic [3:0] I_POP    = 4'hB;
    localparam logic [3:0] REG_NONE = 4'hF;

    localparam logic [2:0] CC_RESET = 3'b100;

    // Pipeline register and condition codes
    logic             out_valid_q, out_valid_d;
    logic [3:0]       out_icode_q, out_ifun_q, out_dst_e_q;
    logic [WIDTH-1:0] out_val_e_q, out_val_a_q;
    logic             out_cnd_q, out_err_q;
    logic [2:0]       cc_q, cc_d;

    logic             accept_c;
    logic             zf_c, sf_c, of_c;
    logic             cond_c, cond_ok_c;
    logic [WIDTH-1:0] alu_res_c;
    logic             alu_ok_c, alu_of_c;
    logic [WIDTH-1:0] val_e_c;
    logic [3:0]       dst_c;
    logic             cnd_c, err_c, cc_we_c;
    logic [WIDTH-1:0] step_c;

    assign in_ready = !out_valid_q || out_ready;
    assign accept_c = in_valid && in_ready;
    assign step_c   = WIDTH'(STACK_STEP);

    assign zf_c = cc_q[2];
    assign sf_c = cc_q[1];
    assign of_c = cc_q[0];

    // Branch/move condition evaluated against the CC held before this instruction
    always_comb begin
        cond_c    = 1'b0;
        cond_ok_c = 1'b1;
        case (in_ifun)
            4'h0:    cond_c = 1'b1;
            4'h1:    cond_c = (sf_c ^ of_c) | zf_c;
            4'h2:    cond_c = sf_c ^ of_c;
            4'h3:    cond_c = zf_c;
            4'h4:    cond_c = !zf_c;
            4'h5:    cond_c = !(sf_c ^ of_c);
            4'h6:    cond_c = !(sf_c ^ of_c) && !zf_c;
            default: cond_ok_c = 1'b0;
        endcase
    end

    // OPq arithmetic and signed-overflow detection
    always_comb begin
        alu_res_c = '0;
        alu_ok_c  = 1'b1;
        alu_of_c  = 1'b0;
        case (in_ifun)
            4'h0: begin
                alu_res_c = in_val_b + in_val_a;
                alu_of_c  = (in_val_a[MSB] == in_val_b[MSB]) && (alu_res_c[MSB] != in_val_b[MSB]);
            end
            4'h1: begin
                alu_res_c = in_val_b - in_val_a;
                alu_of_c  = (in_val_a[MSB] != in_val_b[MSB]) && (alu_res_c[MSB] != in_val_b[MSB]);
            end
            4'h2:    alu_res_c = in_val_b & in_val_a;
            4'h3:    alu_res_c = in_val_b ^ in_val_a;
            default: alu_ok_c  = 1'b0;
        endcase
    end

    // Per-class valE / Cnd / error selection
    always_comb begin
        val_e_c = '0;
        dst_c   = in_dst_e;
        cnd_c   = 1'b0;
        err_c   = 1'b0;
        cc_we_c = 1'b0;
        case (in_icode)
            I_HALT, I_NOP: ;
            I_CMOV: begin
                if (cond_ok_c) begin
                    val_e_c = in_val_a;
                    cnd_c   = cond_c;
                end else begin
                    err_c = 1'b1;
                end
            end
            I_IRMOV:         val_e_c = in_val_c;
            I_RMMOV, I_MRMOV: val_e_c = in_val_b + in_val_c;
            I_OPQ: begin
                if (alu_ok_c) begin
                    val_e_c = alu_res_c;
                    cc_we_c = set_cc_en;
                end else begin
                    err_c = 1'b1;
                end
            end
            I_JXX: begin
                if (cond_ok_c) begin
                    cnd_c = cond_c;
                end else begin
                    err_c = 1'b1;
                end
            end
            I_CALL, I_PUSH:  val_e_c = in_val_b - step_c;
            I_RET, I_POP:    val_e_c = in_val_b + step_c;
            default:         err_c = 1'b1;
        endcase
        // A cmov that does not fire must not write its destination
        if (in_icode == I_CMOV && !cnd_c) begin
            dst_c = REG_NONE;
        end
    end

    always_comb begin
        cc_d = cc_q;
        if (accept_c && cc_we_c) begin
            cc_d = {(alu_res_c == '0), alu_res_c[MSB], alu_of_c};
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (accept_c) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_icode_q <= 4'h0;
            out_ifun_q  <= 4'h0;
            out_val_e_q <= '0;
            out_val_a_q <= '0;
            out_dst_e_q <= REG_NONE;
            out_cnd_q   <= 1'b0;
            out_err_q   <= 1'b0;
            cc_q        <= CC_RESET;
        end else begin
            out_valid_q <= out_valid_d;
            cc_q        <= cc_d;
            if (accept_c) begin
                out_icode_q <= in_icode;
                out_ifun_q  <= in_ifun;
                out_val_e_q <= val_e_c;
                out_val_a_q <= in_val_a;
                out_dst_e_q <= dst_c;
                out_cnd_q   <= cnd_c;
                out_err_q   <= err_c;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_icode = out_icode_q;
    assign out_ifun  = out_ifun_q;
    assign out_val_e = out_val_e_q;
    assign out_val_a = out_val_a_q;
    assign out_dst_e = out_dst_e_q;
    assign out_cnd   = out_cnd_q;
    assign out_err   = out_err_q;
    assign cc_out    = cc_q;

endmodule

// File: tb/tb_exe_stage_p.sv
// Scoreboard bench for exe_stage_p: directed Y86 cases, back-pressure, reset mid-stall,
// then random traffic checked against a behavioural model of the execute rules.
module tb_exe_stage_p;

    localparam int unsigned W    = 64;
    localparam int unsigned STEP = W / 8;

    logic         clock, reset;
    logic         in_valid, in_ready;
    logic [3:0]   in_icode, in_ifun, in_dst_e;
    logic [W-1:0] in_val_a, in_val_b, in_val_c;
    logic         set_cc_en;
    logic         out_valid, out_ready;
    logic [3:0]   out_icode, out_ifun, out_dst_e;
    logic [W-1:0] out_val_e, out_val_a;
    logic         out_cnd, out_err;
    logic [2:0]   cc_out;

    exe_stage_p #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_ifun(in_ifun),
        .in_val_a(in_val_a), .in_val_b(in_val_b), .in_val_c(in_val_c),
        .in_dst_e(in_dst_e), .set_cc_en(set_cc_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_icode(out_icode), .out_ifun(out_ifun),
        .out_val_e(out_val_e), .out_val_a(out_val_a),
        .out_dst_e(out_dst_e), .out_cnd(out_cnd), .out_err(out_err),
        .cc_out(cc_out)
    );

    typedef struct {
        logic [3:0]   icode, ifun, dst;
        logic [W-1:0] val_e, val_a;
        logic         cnd, err;
        logic [2:0]   cc;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] model_cc;
    int         n_err = 0;
    int         n_chk = 0;
    int         rdy_mode = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: applies the execute rules to one accepted instruction
    task automatic model(input logic [3:0] ic, input logic [3:0] ifn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c, input logic [3:0] dst,
                         input logic scc, output exp_t e);
        logic zf, sf, of, take;
        logic signed [W+1:0] sa, sbv, full;
        logic [W-1:0] res;
        logic ovf;
        {zf, sf, of} = model_cc;
        case (ifn)
            4'd0: take = 1'b1;
            4'd1: take = (sf != of) || zf;
            4'd2: take = (sf != of);
            4'd3: take = zf;
            4'd4: take = !zf;
            4'd5: take = (sf == of);
            4'd6: take = (sf == of) && !zf;
            default: take = 1'b0;
        endcase
        e.icode = ic; e.ifun = ifn; e.val_a = a; e.dst = dst;
        e.val_e = '0; e.cnd = 1'b0; e.err = 1'b0;
        case (ic)
            4'd0, 4'd1: ;
            4'd2: begin
                if (ifn > 4'd6) e.err = 1'b1;
                else begin e.val_e = a; e.cnd = take; end
                if (!e.cnd) e.dst = 4'hF;
            end
            4'd3: e.val_e = c;
            4'd4, 4'd5: e.val_e = b + c;
            4'd6: begin
                if (ifn > 4'd3) e.err = 1'b1;
                else begin
                    sa  = $signed({{2{a[W-1]}}, a});
                    sbv = $signed({{2{b[W-1]}}, b});
                    ovf = 1'b0;
                    if (ifn <= 4'd1) begin
                        full = (ifn == 4'd0) ? sbv + sa : sbv - sa;
                        res  = full[W-1:0];
                        ovf  = (full != $signed({{2{res[W-1]}}, res}));
                    end else begin
                        res = (ifn == 4'd2) ? (b & a) : (b ^ a);
                    end
                    e.val_e = res;
                    if (scc) model_cc = {(res == '0), res[W-1], ovf};
                end
            end
            4'd7: begin
                if (ifn > 4'd6) e.err = 1'b1;
                else e.cnd = take;
            end
            4'd8, 4'd10: e.val_e = b - W'(STEP);
            4'd9, 4'd11: e.val_e = b + W'(STEP);
            default: e.err = 1'b1;
        endcase
        e.cc = model_cc;
    endtask

    // Drive one instruction until accepted; the expected result is queued at the accept edge
    task automatic issue(input logic [3:0] ic, input logic [3:0] ifn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c, input logic [3:0] dst,
                         input logic scc);
        exp_t e;
        bit acc;
        int t;
        @(negedge clock);
        in_icode = ic; in_ifun = ifn; in_val_a = a; in_val_b = b; in_val_c = c;
        in_dst_e = dst; set_cc_en = scc; in_valid = 1'b1;
        acc = 1'b0;
        t = 0;
        while (!acc) begin
            #1 acc = in_ready;
            @(posedge clock);
            if (acc) begin
                model(ic, ifn, a, b, c, dst, scc, e);
                sb.push_back(e);
            end else begin
                t++;
                if (t > 100) begin
                    n_chk++; n_err++;
                    $display("FAIL accept_timeout: in_ready stuck at 0 for icode %h", ic);
                    break;
                end
                @(negedge clock);
            end
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 300) begin
            @(negedge clock);
            t++;
        end
        chk("drain_empty", W'(sb.size()), '0);
    endtask

    // Downstream ready: 0 = always, 1 = random, 2 = stalled
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every output handshake pops and checks one expected result
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL spurious_output: icode %h val_e %h with nothing expected", out_icode, out_val_e);
                end else begin
                    e = sb.pop_front();
                    chk("icode", W'(out_icode), W'(e.icode));
                    chk("ifun",  W'(out_ifun),  W'(e.ifun));
                    chk("val_e", out_val_e,     e.val_e);
                    chk("val_a", out_val_a,     e.val_a);
                    chk("dst_e", W'(out_dst_e), W'(e.dst));
                    chk("cnd",   W'(out_cnd),   W'(e.cnd));
                    chk("err",   W'(out_err),   W'(e.err));
                    chk("cc",    W'(cc_out),    W'(e.cc));
                end
            end
        end
    end

    initial begin
        logic [W-1:0] ra, rb, rc;
        reset = 1'b1;
        in_valid = 1'b0; in_icode = '0; in_ifun = '0; in_dst_e = '0;
        in_val_a = '0; in_val_b = '0; in_val_c = '0; set_cc_en = 1'b0;
        model_cc = 3'b100;

        #12;
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_dst_e",     W'(out_dst_e), W'(4'hF));
        chk("rst_val_e",     out_val_e,     '0);
        chk("rst_cc",        W'(cc_out),    W'(3'b100));
        chk("rst_in_ready",  W'(in_ready),  W'(1'b1));
        @(negedge clock);
        reset = 1'b0;

        // Flag setting and condition evaluation
        issue(4'h6, 4'h1, 64'd5, 64'd5, '0, 4'h2, 1'b1);
        issue(4'h7, 4'h3, '0, '0, '0, 4'hF, 1'b1);
        issue(4'h7, 4'h4, '0, '0, '0, 4'hF, 1'b1);
        issue(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, '0, 4'h1, 1'b1);
        issue(4'h2, 4'h2, 64'h55, '0, '0, 4'h3, 1'b1);
        issue(4'h2, 4'h1, 64'h66, '0, '0, 4'h3, 1'b1);
        issue(4'h2, 4'h5, 64'h77, '0, '0, 4'h4, 1'b1);
        // Stack and address arithmetic, including wrap-around
        issue(4'hA, 4'h0, '0, 64'h100, '0, 4'h4, 1'b1);
        issue(4'hB, 4'h0, '0, 64'h100, '0, 4'h4, 1'b1);
        issue(4'h8, 4'h0, '0, 64'h0, '0, 4'h4, 1'b1);
        issue(4'h5, 4'h0, '0, 64'h10, 64'hFFFF_FFFF_FFFF_FFF8, 4'h1, 1'b1);
        issue(4'h3, 4'h0, '0, '0, 64'hDEAD_BEEF, 4'h5, 1'b1);
        // Suppressed CC write and illegal encodings
        issue(4'h6, 4'h3, 64'd3, 64'd3, '0, 4'h6, 1'b0);
        issue(4'h6, 4'h5, 64'd3, 64'd4, '0, 4'h6, 1'b1);
        issue(4'h7, 4'h7, '0, '0, '0, 4'hF, 1'b1);
        issue(4'hD, 4'h0, 64'd9, 64'd9, 64'd9, 4'h1, 1'b1);
        drain();

        // Back-pressure: a pending OPq must neither enter nor touch CC
        rdy_mode = 2;
        @(posedge clock); #3;
        issue(4'h6, 4'h1, 64'd9, 64'd2, '0, 4'h7, 1'b1);
        @(negedge clock);
        in_icode = 4'h6; in_ifun = 4'h0; in_val_a = 64'd1; in_val_b = 64'd1;
        in_dst_e = 4'h8; set_cc_en = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready",  W'(in_ready),  '0);
            chk("stall_out_valid", W'(out_valid), W'(1'b1));
            chk("stall_val_e",     out_val_e,     sb[0].val_e);
            chk("stall_dst_e",     W'(out_dst_e), W'(sb[0].dst));
            chk("stall_cc",        W'(cc_out),    W'(model_cc));
            @(negedge clock);
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        issue(4'h6, 4'h0, 64'd1, 64'd1, '0, 4'h8, 1'b1);
        issue(4'h6, 4'h2, 64'hF0, 64'h0F, '0, 4'h9, 1'b1);
        drain();

        // Random traffic with random downstream stalls
        rdy_mode = 1;
        for (int n = 0; n < 400; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 4)) : {$urandom, $urandom};
            rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) rb = {1'b0, {(W-1){1'b1}}};
            rc = {$urandom, $urandom};
            issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)), ra, rb, rc,
                  4'($urandom_range(0, 15)), ($urandom_range(0, 4) != 0));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
        end
        rdy_mode = 0;
        drain();

        // Asynchronous reset while a result is stalled
        rdy_mode = 2;
        @(posedge clock); #3;
        issue(4'h6, 4'h0, 64'd1, 64'd1, '0, 4'h2, 1'b1);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", W'(out_valid), '0);
        chk("arst_cc",        W'(cc_out),    W'(3'b100));
        chk("arst_dst_e",     W'(out_dst_e), W'(4'hF));
        chk("arst_val_e",     out_val_e,     '0);
        chk("arst_err",       W'(out_err),   '0);
        sb.delete();
        model_cc = 3'b100;
        @(negedge clock);
        reset = 1'b0;
        rdy_mode = 0;
        issue(4'hD, 4'h2, 64'd7, 64'd7, 64'd7, 4'h3, 1'b1);
        issue(4'h7, 4'h3, '0, '0, '0, 4'hF, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
